// File: rtl/plant_if.sv
// Plant-side signal bundle: actuator command in, simulated measurement out.
// Handshake: enable is a level qualifier. sample_valid is a one-cycle pulse with no ready and no backpressure; the consumer must take feedback_out on that cycle.
interface plant_if;
  logic       enable;
  logic [7:0] control_in;
  logic [7:0] feedback_out;
  logic       sample_valid;

  modport master (output enable, output control_in, input feedback_out, input sample_valid);
  modport slave  (input enable, input control_in, output feedback_out, output sample_valid);
endinterface

// File: rtl/plant_model.sv
// First-order lag plant with transport dead time, stepped once every TICK_DIV+2 clocks.
// FSM state and tick counter are exported on o_dbg_state / o_dbg_cnt.
module plant_model #(
  parameter int unsigned TAU_SHIFT = 2,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned DELAY     = 2,
  localparam int CNT_W = $clog2(TICK_DIV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  plant_if.slave           bus,
  output logic [1:0]       o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_SHIFT  = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       r_dly [DELAY+1];
  logic [7:0]       r_fb;
  logic             r_valid;

  logic signed [9:0] w_diff;
  logic signed [9:0] w_step;
  logic signed [9:0] w_y_next;
  logic [7:0]        w_y_clamped;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bus.enable) w_state_next = S_COUNT;
      end
      S_COUNT: begin
        if (!bus.enable) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_SHIFT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      // SHIFT always completes so the delay line and the update stay paired.
      S_SHIFT: begin
        w_state_next = S_UPDATE;
        w_cnt_next   = '0;
      end
      S_UPDATE: begin
        w_cnt_next   = '0;
        w_state_next = bus.enable ? S_COUNT : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Arithmetic shift floors, so rising steps may stall short of the target while falling ones do not.
  assign w_diff   = $signed({2'b00, r_dly[DELAY]}) - $signed({2'b00, r_fb});
  assign w_step   = w_diff >>> TAU_SHIFT;
  assign w_y_next = $signed({2'b00, r_fb}) + w_step;

  always_comb begin
    w_y_clamped = w_y_next[7:0];
    if (w_y_next[9])      w_y_clamped = 8'd0;
    else if (w_y_next[8]) w_y_clamped = 8'd255;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= DELAY; k++) r_dly[k] <= 8'd0;
      r_fb    <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_SHIFT) begin
        r_dly[0] <= bus.control_in;
        for (int k = 1; k <= DELAY; k++) r_dly[k] <= r_dly[k-1];
      end
      if (r_state == S_UPDATE) begin
        r_fb    <= w_y_clamped;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.feedback_out = r_fb;
  assign bus.sample_valid = r_valid;
  assign o_dbg_state      = r_state;
  assign o_dbg_cnt        = r_cnt;

endmodule

// File: tb/tb_plant_model.sv
// Directed bench for plant_model with TAU_SHIFT=2, TICK_DIV=4, DELAY=2.
module tb_plant_model;
  localparam int TAU_SHIFT = 2;
  localparam int TICK_DIV  = 4;
  localparam int DELAY     = 2;
  localparam int CNT_W     = $clog2(TICK_DIV + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_cnt;
  int               checks = 0;
  int               errors = 0;
  int               n_pulses;
  logic [7:0]       exp_q[$];
  logic [7:0]       e;
  logic             pulse;

  plant_if bus();

  plant_model #(
    .TAU_SHIFT(TAU_SHIFT),
    .TICK_DIV (TICK_DIV),
    .DELAY    (DELAY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state),
    .o_dbg_cnt  (dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_dly(input string tag, input int e0, input int e1, input int e2);
    check({tag, "_dly0"}, int'(dut.r_dly[0]), e0);
    check({tag, "_dly1"}, int'(dut.r_dly[1]), e1);
    check({tag, "_dly2"}, int'(dut.r_dly[2]), e2);
  endtask

  initial begin
    // reset held with enable high and a nonzero command
    rst_n          = 1'b0;
    bus.enable     = 1'b1;
    bus.control_in = 8'hAA;
    tick();
    tick();
    check("rst_fb", int'(bus.feedback_out), 0);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_state", int'(dbg_state), 0);
    check("rst_cnt", int'(dbg_cnt), 0);
    check_dly("rst", 0, 0, 0);

    // step to 200, dropping to 0 after the third update: 0,0,50,87,115 then decay 86,64,48,36,27
    exp_q = {8'd0, 8'd0, 8'd50, 8'd87, 8'd115, 8'd86, 8'd64, 8'd48, 8'd36, 8'd27};
    rst_n          = 1'b1;
    bus.control_in = 8'd200;
    n_pulses       = 0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (k == 1) begin
        check("first_state", int'(dbg_state), 1);
        check("first_cnt", int'(dbg_cnt), 0);
      end
      pulse = (k >= 7) && (((k - 1) % 6) == 0);
      if (bus.sample_valid) n_pulses++;
      check("period_valid", int'(bus.sample_valid), int'(pulse));
      if (pulse && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("step_fb", int'(bus.feedback_out), int'(e));
      end
      if (k == 19) bus.control_in = 8'd0;
    end
    check("pulse_count", n_pulses, 10);
    check_dly("decay", 0, 0, 0);

    // one more update with 100 entering the line: u_eff=0, 27 -> 20
    bus.control_in = 8'd100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("u11_valid", int'(bus.sample_valid), int'(k == 6));
    end
    check("u11_fb", int'(bus.feedback_out), 20);
    check_dly("u11", 100, 0, 0);

    // enable drop at cnt=2 for five cycles
    tick();
    tick();
    check("pre_drop_state", int'(dbg_state), 1);
    check("pre_drop_cnt", int'(dbg_cnt), 2);
    bus.enable     = 1'b0;
    bus.control_in = 8'd150;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("drop_state", int'(dbg_state), 0);
      check("drop_cnt", int'(dbg_cnt), 0);
      check("drop_valid", int'(bus.sample_valid), 0);
      check("drop_fb", int'(bus.feedback_out), 20);
    end
    check_dly("drop", 100, 0, 0);

    // reassert: pulse 6 cycles after the first enabled edge; u_eff=0, 20 -> 15
    bus.enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("reen_valid", int'(bus.sample_valid), int'(k == 7));
    end
    check("reen_fb", int'(bus.feedback_out), 15);
    check_dly("reen", 150, 100, 0);

    // walk to UPDATE, then reset on that cycle
    for (int k = 1; k <= 5; k++) tick();
    check("at_update_state", int'(dbg_state), 3);
    check_dly("at_update", 150, 150, 100);
    rst_n = 1'b0;
    tick();
    check("rstupd_valid", int'(bus.sample_valid), 0);
    check("rstupd_fb", int'(bus.feedback_out), 0);
    check("rstupd_state", int'(dbg_state), 0);
    check("rstupd_cnt", int'(dbg_cnt), 0);
    check_dly("rstupd", 0, 0, 0);

    // restart after reset: first update sees u_eff=0 from a cleared line
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("restart_valid", int'(bus.sample_valid), int'(k == 7));
    end
    check("restart_fb", int'(bus.feedback_out), 0);
    check_dly("restart", 150, 0, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plant_model.md
PLANT_MODEL -- requirements
Module: plant_model

Interface
REQ-001 The block SHALL take parameter TAU_SHIFT, default 2: lag time constant as a right-shift amount, legal range 0..7.
REQ-002 The block SHALL take parameter TICK_DIV, default 4: clocks spent in COUNT per update, minimum 1.
REQ-003 The block SHALL take parameter DELAY, default 2: transport dead time in updates, legal range 0..7.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: run the plant simulation while high.
REQ-007 The block SHALL have port control_in, input, 8 bits, unsigned: actuator command, the controller's control output.
REQ-008 The block SHALL have port feedback_out, output, 8 bits, unsigned, registered: simulated plant measurement, wired back to the controller's feedback input.
REQ-009 The block SHALL have port sample_valid, output, 1 bit, registered: one-cycle pulse marking a new feedback_out value.

Function
REQ-010 The block SHALL implement the FSM states IDLE, COUNT, SHIFT and UPDATE, plus a counter cnt of ceil(log2(TICK_DIV+1)) bits.
REQ-011 IDLE SHALL behave as follows: outputs hold; enable=1 -> COUNT with cnt=0; enable=0 -> stay in IDLE.
REQ-012 COUNT SHALL behave as follows: cnt increments each cycle; when cnt==TICK_DIV-1 -> SHIFT; enable=0 at any cycle -> IDLE and cnt cleared.
REQ-013 SHIFT SHALL behave as follows: sample control_in into delay line entry 0; entry k takes entry k-1 for k=1..DELAY; -> UPDATE; enable is ignored.
REQ-014 UPDATE SHALL behave as follows: u_eff = delay line entry DELAY after the shift; -> COUNT with cnt=0 if enable=1, else -> IDLE.
REQ-015 The delay line SHALL have DELAY+1 entries of 8 bits, so u_eff at update k equals the control_in value sampled at update k-DELAY; with DELAY=0, u_eff is the current sample.
REQ-016 UPDATE arithmetic SHALL compute diff = u_eff - y as a 10-bit signed value; step = diff >>> TAU_SHIFT, an arithmetic shift that rounds toward negative infinity; y_next = y + step, computed 10-bit signed.
REQ-017 y_next SHALL be clamped to 0..255 before it is registered into feedback_out.
REQ-018 Convergence SHALL follow from REQ-016: upward steps can stall up to 2^TAU_SHIFT-1 below u_eff; downward steps always reach u_eff; this behaviour is required.
REQ-019 feedback_out and sample_valid SHALL update on the edge ending UPDATE; sample_valid SHALL be high for exactly that one following cycle and low otherwise.
REQ-020 The update period with enable held high SHALL be TICK_DIV+2 cycles.
REQ-021 The delay line contents and feedback_out SHALL be retained across IDLE; enable dropping SHALL NOT clear plant state.
REQ-022 An illegal FSM encoding SHALL go to IDLE on the next edge.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, cnt=0, all delay line entries=0, feedback_out=0x00 and sample_valid=0.
REQ-024 Reset SHALL take priority in every state, including mid-SHIFT and mid-UPDATE; no partial update SHALL be visible after reset.
REQ-025 After rst_n is released, the first sample_valid SHALL occur TICK_DIV+2 cycles after the first edge with enable=1.

Verification (TAU_SHIFT=2, TICK_DIV=4, DELAY=2)
REQ-026 Reset scenario: hold rst_n=0 for 2 cycles with control_in=0xAA and enable=1 -> feedback_out=0, sample_valid=0; the first pulse arrives 6 cycles after release.
REQ-027 Step scenario: reset, then control_in=200 and enable=1 held -> feedback_out per update = 0, 0, 50, 87, 115.
REQ-028 Period scenario: enable=1 for 60 cycles -> sample_valid pulses exactly every 6 cycles, each 1 cycle wide, 10 pulses in total.
REQ-029 Down-step scenario: from y=115 with the delay line full of 0 -> next feedback_out=86, since -115>>>2 = -29.
REQ-030 Enable-drop scenario: deassert enable at cnt=2 for 5 cycles, then reassert -> no pulse and feedback_out held while low; the next pulse arrives 6 cycles after reassertion; the delay line is unchanged.
REQ-031 Reset-during-UPDATE scenario: assert rst_n=0 on the UPDATE cycle -> no sample_valid, feedback_out=0 and the delay line cleared on the following cycle.
